legv8_pc_sequencer: RTL and testbench
=====================================

# legv8_pc_sequencer

Parametrised fetch-sequencing and decode-control unit for the single-issue LEGv8 core. It sits between instruction memory and the register file/ALU datapath. It owns the PC and registers one decoded control word per accepted instruction. It computes branch targets internally, resolves CBZ/CBNZ through a wait state on the ALU zero flag, honours a downstream stall, flags unknown opcodes and counts retired instructions.

## Interface
- PC_WIDTH, 64: PC and target width; must be ≥ 28.
- RESET_PC, 0: PC value loaded on reset.
- CNT_WIDTH, 32: width of the instruction counter.
- CLOCK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  instruction word for the current PC.
- INSTR_VALID  in  1  INSTRUCTION is valid for the current PC.
- STALL  in  1  downstream hazard; blocks acceptance.
- ALU_ZERO  in  1  zero flag for the pending CBZ/CBNZ operand.
- ALU_ZERO_VALID  in  1  ALU_ZERO is valid this cycle.
- FETCH_REQ  out  1  fetch request for PC.
- PC  out  PC_WIDTH  current fetch address.
- CTRL_VALID  out  1  one-cycle pulse: control outputs hold a newly accepted instruction.
- REG2LOC, REGWRITE, MEMREAD, MEMWRITE, MEM2REG, ALUSRC, BRANCH, UNCON_BRANCH  out  1 each  datapath control bits.
- ALU_OP  out  2  ALU class.
- READ_REG_1, READ_REG_2, WRITE_REG  out  5 each  register specifiers.
- ILLEGAL  out  1  one-cycle pulse on acceptance of an unknown opcode.
- INSTR_COUNT  out  CNT_WIDTH  accepted-instruction count; saturates at all-ones.

## Operation
- States: FETCH, RESOLVE.
- Acceptance occurs on a rising edge when state=FETCH, INSTR_VALID=1 and STALL=0. INSTRUCTION is decoded and registered at that edge, CTRL_VALID=1 for the following cycle, and INSTR_COUNT increments.
- Decode keys and outputs, listed as REG2LOC, REGWRITE, MEMREAD, MEMWRITE, MEM2REG, ALUSRC, BRANCH, UNCON_BRANCH, ALU_OP:
  - B, [31:26]=000101: 0,0,0,0,0,0,0,1,00.
  - CBZ, [31:24]=10110100, and CBNZ, [31:24]=10110101: 1,0,0,0,0,0,1,0,01.
  - LDUR, [31:21]=11111000010: 0,1,1,0,1,1,0,0,00.
  - STUR, [31:21]=11111000000: 1,0,0,1,0,1,0,0,00.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: 0,1,0,0,0,0,0,0,10.
  - Any other opcode: all control bits 0, ALU_OP=00, ILLEGAL pulses.
- Register specifiers:
  - READ_REG_1=[9:5].
  - READ_REG_2=[4:0] when REG2LOC=1, otherwise [20:16].
  - WRITE_REG=[4:0].
- Branch targets:
  - B: PC + (sign_extend(imm26 [25:0]) << 2).
  - CBZ/CBNZ: PC + (sign_extend(imm19 [23:5]) << 2).
  - All PC arithmetic is modulo 2^PC_WIDTH; there is no overflow detection.
- Next PC on acceptance:
  - Non-branch or illegal: PC+4; stay in FETCH.
  - B: target; stay in FETCH.
  - CBZ/CBNZ: capture the target, hold PC, go to RESOLVE.
- RESOLVE:
  - FETCH_REQ=0 and INSTR_VALID is ignored.
  - On the first edge with ALU_ZERO_VALID=1, the branch is taken when CBZ&ALU_ZERO or CBNZ&!ALU_ZERO.
  - Taken: PC ← target. Not taken: PC ← PC+4. In both cases return to FETCH.
  - STALL has no effect in RESOLVE.
- Between acceptances, control outputs and specifiers hold their last values, and CTRL_VALID, ILLEGAL=0.

## Timing
- Reset state (RESET_N low, asynchronous):
  - PC=RESET_PC, state=FETCH, FETCH_REQ=0.
  - All control bits 0, ALU_OP=00, all specifiers 0.
  - CTRL_VALID=0, ILLEGAL=0, INSTR_COUNT=0.
- FETCH_REQ=1 exactly when state=FETCH and RESET_N=1, starting the first cycle after release.
- Decode latency: 1 cycle. Control outputs and the new PC are visible in the cycle after the acceptance edge.
- Back-to-back acceptance is allowed every cycle in FETCH (throughput 1/cycle).
- CBZ/CBNZ minimum occupancy is 2 cycles (acceptance + RESOLVE). ALU_ZERO_VALID in the acceptance cycle itself is ignored.
- STALL=1 with INSTR_VALID=1: no acceptance; PC, outputs and counter are unchanged; CTRL_VALID=0.
- Reset asserted mid-RESOLVE discards the pending branch and returns to the reset state.
- INSTR_COUNT saturates: at all-ones it is unchanged on acceptance.
- PC+4 from 2^PC_WIDTH−4 wraps to 0.

## Test plan
- Release reset, hold INSTR_VALID=1, INSTRUCTION=0x8B020023 (ADD X3,X1,X2) for 3 cycles -> PC 0→4→8→12; CTRL_VALID=1 each cycle; REGWRITE=1, ALU_OP=10, READ_REG_1=1, READ_REG_2=2, WRITE_REG=3; INSTR_COUNT=3.
- At PC=0x10, accept 0x14000002 (B +8) -> next PC=0x18, UNCON_BRANCH=1, state stays FETCH.
- At PC=0x20, accept 0xB4FFFFE5 (CBZ X5,−4), wait 2 cycles, then ALU_ZERO_VALID=1, ALU_ZERO=1 -> FETCH_REQ=0 while waiting, READ_REG_2=5, REG2LOC=1, then PC=0x1C. Repeat with ALU_ZERO=0 -> PC=0x24. Same as CBNZ (0xB5FFFFE5) -> outcomes inverted.
- STALL=1 for 2 cycles with valid LDUR 0xF8408041 -> PC and INSTR_COUNT are frozen and CTRL_VALID=0. After STALL drops -> one acceptance, MEMREAD=1, MEM2REG=1, ALUSRC=1.
- Accept 0x00000000 -> ILLEGAL pulse, all control bits 0, PC+4.
- Assert RESET_N low mid-RESOLVE with RESET_PC=0x400 -> PC=0x400 immediately, outputs cleared. With CNT_WIDTH=2, after 5 acceptances -> INSTR_COUNT=3.

Source files
------------

// File: rtl/legv8_pc_sequencer.sv
// LEGv8 fetch sequencer and decode-control unit.
// Owns the PC, decodes one instruction per acceptance into a registered
// control word, resolves CBZ/CBNZ through a RESOLVE wait state on the ALU
// zero flag, and counts accepted instructions with saturation.
module legv8_pc_sequencer #(
  parameter int                  PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic [31:0]          INSTRUCTION,
  input  logic                 INSTR_VALID,
  input  logic                 STALL,
  input  logic                 ALU_ZERO,
  input  logic                 ALU_ZERO_VALID,
  output logic                 FETCH_REQ,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 CTRL_VALID,
  output logic                 REG2LOC,
  output logic                 REGWRITE,
  output logic                 MEMREAD,
  output logic                 MEMWRITE,
  output logic                 MEM2REG,
  output logic                 ALUSRC,
  output logic                 BRANCH,
  output logic                 UNCON_BRANCH,
  output logic [1:0]           ALU_OP,
  output logic [4:0]           READ_REG_1,
  output logic [4:0]           READ_REG_2,
  output logic [4:0]           WRITE_REG,
  output logic                 ILLEGAL,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

  typedef enum logic {FETCH = 1'b0, RESOLVE = 1'b1} state_t;

  typedef struct packed {
    logic       reg2loc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       mem2reg;
    logic       alusrc;
    logic       branch;
    logic       uncon;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t              state;
  logic [PC_WIDTH-1:0] target_q;
  logic                cbnz_q;

  ctrl_t               dec;
  logic                dec_ill, is_b, is_cb;
  logic [4:0]          dec_rr2;
  logic [PC_WIDTH-1:0] b_off, cb_off, pc_inc;
  logic                accept, take;

  // Opcode decode of the word presented this cycle.
  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    is_b    = 1'b0;
    is_cb   = 1'b0;
    if (INSTRUCTION[31:26] == 6'b000101) begin
      dec.uncon = 1'b1;
      is_b      = 1'b1;
    end else if (INSTRUCTION[31:25] == 7'b1011010) begin
      // bit 24 separates CBZ (0) from CBNZ (1); decode is identical
      dec.reg2loc = 1'b1;
      dec.branch  = 1'b1;
      dec.alu_op  = 2'b01;
      is_cb       = 1'b1;
    end else begin
      unique case (INSTRUCTION[31:21])
        11'b11111000010: begin
          dec.regwrite = 1'b1;
          dec.memread  = 1'b1;
          dec.mem2reg  = 1'b1;
          dec.alusrc   = 1'b1;
        end
        11'b11111000000: begin
          dec.reg2loc  = 1'b1;
          dec.memwrite = 1'b1;
          dec.alusrc   = 1'b1;
        end
        11'b10001011000, 11'b11001011000,
        11'b10001010000, 11'b10101010000: begin
          dec.regwrite = 1'b1;
          dec.alu_op   = 2'b10;
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  assign dec_rr2 = dec.reg2loc ? INSTRUCTION[4:0] : INSTRUCTION[20:16];
  // Word offsets sign-extended to PC width; PC_WIDTH >= 28 keeps the shift lossless.
  assign b_off   = {{(PC_WIDTH-26){INSTRUCTION[25]}}, INSTRUCTION[25:0]} << 2;
  assign cb_off  = {{(PC_WIDTH-19){INSTRUCTION[23]}}, INSTRUCTION[23:5]} << 2;
  assign pc_inc  = PC + PC_WIDTH'(4);
  assign accept  = (state == FETCH) && INSTR_VALID && !STALL;
  assign take    = cbnz_q ? !ALU_ZERO : ALU_ZERO;

  // Sequencer FSM, PC, registered control word and retire counter.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= FETCH;
      PC           <= RESET_PC;
      target_q     <= '0;
      cbnz_q       <= 1'b0;
      FETCH_REQ    <= 1'b0;
      CTRL_VALID   <= 1'b0;
      ILLEGAL      <= 1'b0;
      REG2LOC      <= 1'b0;
      REGWRITE     <= 1'b0;
      MEMREAD      <= 1'b0;
      MEMWRITE     <= 1'b0;
      MEM2REG      <= 1'b0;
      ALUSRC       <= 1'b0;
      BRANCH       <= 1'b0;
      UNCON_BRANCH <= 1'b0;
      ALU_OP       <= 2'b00;
      READ_REG_1   <= 5'd0;
      READ_REG_2   <= 5'd0;
      WRITE_REG    <= 5'd0;
      INSTR_COUNT  <= '0;
    end else begin
      CTRL_VALID <= 1'b0;
      ILLEGAL    <= 1'b0;
      unique case (state)
        FETCH: begin
          FETCH_REQ <= 1'b1;
          if (accept) begin
            CTRL_VALID   <= 1'b1;
            ILLEGAL      <= dec_ill;
            REG2LOC      <= dec.reg2loc;
            REGWRITE     <= dec.regwrite;
            MEMREAD      <= dec.memread;
            MEMWRITE     <= dec.memwrite;
            MEM2REG      <= dec.mem2reg;
            ALUSRC       <= dec.alusrc;
            BRANCH       <= dec.branch;
            UNCON_BRANCH <= dec.uncon;
            ALU_OP       <= dec.alu_op;
            READ_REG_1   <= INSTRUCTION[9:5];
            READ_REG_2   <= dec_rr2;
            WRITE_REG    <= INSTRUCTION[4:0];
            if (INSTR_COUNT != '1) INSTR_COUNT <= INSTR_COUNT + CNT_WIDTH'(1);
            if (is_b) begin
              PC <= PC + b_off;
            end else if (is_cb) begin
              // hold PC until the zero flag arrives
              target_q  <= PC + cb_off;
              cbnz_q    <= INSTRUCTION[24];
              state     <= RESOLVE;
              FETCH_REQ <= 1'b0;
            end else begin
              PC <= pc_inc;
            end
          end
        end
        RESOLVE: begin
          if (ALU_ZERO_VALID) begin
            PC        <= take ? target_q : pc_inc;
            state     <= FETCH;
            FETCH_REQ <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_pc_sequencer.sv
// Scoreboard bench for legv8_pc_sequencer: directed vectors push expected
// control words on acceptance; a negedge monitor pops on CTRL_VALID.
module tb_legv8_pc_sequencer;

  typedef struct {
    logic [63:0] pc;
    logic [7:0]  ctl;
    logic [1:0]  aluop;
    logic [4:0]  r1, r2, wr;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [7:0] C_ALU  = 8'b01000000;
  localparam logic [7:0] C_B    = 8'b00000001;
  localparam logic [7:0] C_CB   = 8'b10000010;
  localparam logic [7:0] C_LD   = 8'b01101100;
  localparam logic [7:0] C_ST   = 8'b10010100;
  localparam logic [7:0] C_NONE = 8'b00000000;
  localparam logic [31:0] I_ADD = 32'h8B020023;

  logic CLOCK = 1'b0;
  logic RESET_N, RESET_N2;
  logic [31:0] INSTRUCTION;
  logic INSTR_VALID, INSTR_VALID2, STALL, ALU_ZERO, ALU_ZERO_VALID;

  logic fetch_req, ctrl_valid, reg2loc, regwrite, memread, memwrite, mem2reg, alusrc, branch, uncon, illegal;
  logic [63:0] pc;
  logic [1:0]  alu_op;
  logic [4:0]  rr1, rr2, wr;
  logic [31:0] cnt;

  logic fetch_req2, ctrl_valid2, reg2loc2, regwrite2, memread2, memwrite2, mem2reg2, alusrc2, branch2, uncon2, illegal2;
  logic [63:0] pc2;
  logic [1:0]  alu_op2;
  logic [4:0]  rr1_2, rr2_2, wr2;
  logic [1:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t e;

  always #5 CLOCK = ~CLOCK;

  legv8_pc_sequencer #(.PC_WIDTH(64), .RESET_PC(64'h0), .CNT_WIDTH(32)) u_dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .STALL(STALL), .ALU_ZERO(ALU_ZERO), .ALU_ZERO_VALID(ALU_ZERO_VALID),
    .FETCH_REQ(fetch_req), .PC(pc), .CTRL_VALID(ctrl_valid),
    .REG2LOC(reg2loc), .REGWRITE(regwrite), .MEMREAD(memread), .MEMWRITE(memwrite),
    .MEM2REG(mem2reg), .ALUSRC(alusrc), .BRANCH(branch), .UNCON_BRANCH(uncon),
    .ALU_OP(alu_op), .READ_REG_1(rr1), .READ_REG_2(rr2), .WRITE_REG(wr),
    .ILLEGAL(illegal), .INSTR_COUNT(cnt)
  );

  legv8_pc_sequencer #(.PC_WIDTH(64), .RESET_PC(64'h400), .CNT_WIDTH(2)) u_dut2 (
    .CLOCK(CLOCK), .RESET_N(RESET_N2), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID2),
    .STALL(STALL), .ALU_ZERO(ALU_ZERO), .ALU_ZERO_VALID(ALU_ZERO_VALID),
    .FETCH_REQ(fetch_req2), .PC(pc2), .CTRL_VALID(ctrl_valid2),
    .REG2LOC(reg2loc2), .REGWRITE(regwrite2), .MEMREAD(memread2), .MEMWRITE(memwrite2),
    .MEM2REG(mem2reg2), .ALUSRC(alusrc2), .BRANCH(branch2), .UNCON_BRANCH(uncon2),
    .ALU_OP(alu_op2), .READ_REG_1(rr1_2), .READ_REG_2(rr2_2), .WRITE_REG(wr2),
    .ILLEGAL(illegal2), .INSTR_COUNT(cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] p, input logic [7:0] c, input logic [1:0] a,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                              input logic il, input logic [31:0] n);
    exp_t x;
    x.pc = p; x.ctl = c; x.aluop = a; x.r1 = r1; x.r2 = r2; x.wr = w; x.ill = il; x.cnt = n;
    return x;
  endfunction

  // Monitor: every CTRL_VALID pulse must match the oldest pending expectation.
  always @(negedge CLOCK) begin
    if (RESET_N && ctrl_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ctrl_valid act=1 exp=0 pc=%h", pc);
      end else begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("ctl", {56'd0, reg2loc, regwrite, memread, memwrite, mem2reg, alusrc, branch, uncon}, {56'd0, e.ctl});
        chk("alu_op", {62'd0, alu_op}, {62'd0, e.aluop});
        chk("read_reg_1", {59'd0, rr1}, {59'd0, e.r1});
        chk("read_reg_2", {59'd0, rr2}, {59'd0, e.r2});
        chk("write_reg", {59'd0, wr}, {59'd0, e.wr});
        chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
        chk("instr_count", {32'd0, cnt}, {32'd0, e.cnt});
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input exp_t x);
    @(negedge CLOCK);
    INSTRUCTION = ins; INSTR_VALID = 1'b1; STALL = 1'b0;
    sb.push_back(x);
  endtask

  // CBZ/CBNZ: accept, trap a zero flag in the acceptance cycle, wait two
  // cycles with garbage fetch/stall inputs, then deliver the real flag.
  task automatic cb(input logic [31:0] ins, input logic [63:0] apc, input logic az,
                    input logic [63:0] exp_pc, input logic [31:0] n);
    issue(ins, mk(apc, C_CB, 2'b01, 5'd31, 5'd5, 5'd5, 1'b0, n));
    ALU_ZERO_VALID = 1'b1; ALU_ZERO = ~az;
    repeat (2) begin
      @(negedge CLOCK);
      ALU_ZERO_VALID = 1'b0; INSTRUCTION = I_ADD; INSTR_VALID = 1'b1; STALL = 1'b1;
      chk("resolve_fetch_req", {63'd0, fetch_req}, 64'd0);
      chk("resolve_pc_hold", pc, apc);
    end
    @(negedge CLOCK);
    ALU_ZERO_VALID = 1'b1; ALU_ZERO = az; INSTR_VALID = 1'b0;
    @(negedge CLOCK);
    ALU_ZERO_VALID = 1'b0; STALL = 1'b0;
    chk("resolve_pc", pc, exp_pc);
    chk("resolve_fetch_req_back", {63'd0, fetch_req}, 64'd1);
  endtask

  initial begin
    RESET_N = 1'b0; RESET_N2 = 1'b0;
    INSTRUCTION = '0; INSTR_VALID = 1'b0; INSTR_VALID2 = 1'b0;
    STALL = 1'b0; ALU_ZERO = 1'b0; ALU_ZERO_VALID = 1'b0;
    #12;
    chk("rst_pc", pc, 64'h0);
    chk("rst_fetch_req", {63'd0, fetch_req}, 64'd0);
    chk("rst_ctrl_valid", {63'd0, ctrl_valid}, 64'd0);
    chk("rst_count", {32'd0, cnt}, 64'd0);
    chk("rst_ctl", {56'd0, reg2loc, regwrite, memread, memwrite, mem2reg, alusrc, branch, uncon, alu_op}, 64'd0);
    chk("rst_spec", {49'd0, rr1, rr2, wr}, 64'd0);
    chk("rst2_pc", pc2, 64'h400);
    @(negedge CLOCK); RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("fetch_req_after_release", {63'd0, fetch_req}, 64'd1);
    chk("pc_after_release", pc, 64'h0);

    // back-to-back ALU ops
    issue(I_ADD, mk(64'h04, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 1));
    issue(I_ADD, mk(64'h08, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 2));
    issue(I_ADD, mk(64'h0C, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 3));
    issue(I_ADD, mk(64'h10, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 4));
    // B +8 from 0x10
    issue(32'h14000002, mk(64'h18, C_B, 2'b00, 5'd0, 5'd0, 5'd2, 1'b0, 5));
    issue(I_ADD, mk(64'h1C, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 6));
    issue(I_ADD, mk(64'h20, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 7));
    // CBZ X5,-4 at 0x20: taken, then not taken; CBNZ inverted
    cb(32'hB4FFFFE5, 64'h20, 1'b1, 64'h1C, 8);
    issue(I_ADD, mk(64'h20, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 9));
    cb(32'hB4FFFFE5, 64'h20, 1'b0, 64'h24, 10);
    cb(32'hB5FFFFE5, 64'h24, 1'b1, 64'h28, 11);
    cb(32'hB5FFFFE5, 64'h28, 1'b0, 64'h24, 12);

    // stall holds a valid LDUR
    @(negedge CLOCK);
    INSTRUCTION = 32'hF8408041; INSTR_VALID = 1'b1; STALL = 1'b1;
    repeat (2) begin
      @(negedge CLOCK);
      chk("stall_pc", pc, 64'h24);
      chk("stall_count", {32'd0, cnt}, 64'd12);
      chk("stall_ctrl_valid", {63'd0, ctrl_valid}, 64'd0);
    end
    STALL = 1'b0;
    sb.push_back(mk(64'h28, C_LD, 2'b00, 5'd2, 5'd0, 5'd1, 1'b0, 13));
    issue(32'hF8000041, mk(64'h2C, C_ST, 2'b00, 5'd2, 5'd1, 5'd1, 1'b0, 14));
    issue(32'h00000000, mk(64'h30, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 15));
    issue(32'hCB020023, mk(64'h34, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 16));
    issue(32'hAA020023, mk(64'h38, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 17));
    issue(32'h8A020023, mk(64'h3C, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 18));
    issue(32'h8B220023, mk(64'h40, C_NONE, 2'b00, 5'd1, 5'd2, 5'd3, 1'b1, 19));
    // B -0x44 lands on 2^64-4, then PC+4 wraps to 0
    issue(32'h17FFFFEF, mk(64'hFFFF_FFFF_FFFF_FFFC, C_B, 2'b00, 5'd31, 5'd31, 5'd15, 1'b0, 20));
    issue(I_ADD, mk(64'h0, C_ALU, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 21));
    @(negedge CLOCK); INSTR_VALID = 1'b0;
    repeat (3) @(negedge CLOCK);

    // second instance: 2-bit counter saturation, reset mid-RESOLVE
    RESET_N2 = 1'b1;
    INSTRUCTION = I_ADD;
    @(negedge CLOCK); INSTR_VALID2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLOCK);
      chk("sat_count", {62'd0, cnt2}, (i > 3) ? 64'd3 : 64'(i));
      chk("sat_pc", pc2, 64'h400 + 64'(4 * i));
    end
    INSTRUCTION = 32'hB4FFFFE5;
    @(negedge CLOCK); INSTR_VALID2 = 1'b0;
    chk("dut2_cbz_reg2loc", {63'd0, reg2loc2}, 64'd1);
    chk("dut2_cbz_pc_hold", pc2, 64'h414);
    chk("dut2_cbz_fetch_req", {63'd0, fetch_req2}, 64'd0);
    #2 RESET_N2 = 1'b0;
    #1;
    chk("midrst_pc", pc2, 64'h400);
    chk("midrst_ctrl_valid", {63'd0, ctrl_valid2}, 64'd0);
    chk("midrst_ctl", {56'd0, reg2loc2, regwrite2, memread2, memwrite2, mem2reg2, alusrc2, branch2, uncon2, alu_op2}, 64'd0);
    chk("midrst_spec", {49'd0, rr1_2, rr2_2, wr2}, 64'd0);
    chk("midrst_count", {62'd0, cnt2}, 64'd0);
    chk("midrst_fetch_req", {63'd0, fetch_req2}, 64'd0);
    @(negedge CLOCK); RESET_N2 = 1'b1; ALU_ZERO_VALID = 1'b1; ALU_ZERO = 1'b1;
    @(negedge CLOCK); ALU_ZERO_VALID = 1'b0;
    chk("postrst_pc", pc2, 64'h400);
    chk("postrst_fetch_req", {63'd0, fetch_req2}, 64'd1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLOCK);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
